// File: rtl/tff_pkg.sv
// tff_pkg: shared defaults and reset polarity for the toggle flip-flop family
package tff_pkg;
  localparam int TFF_WIDTH = 1;
  localparam int TFF_MAX_WIDTH = 64;
  localparam logic [TFF_MAX_WIDTH-1:0] TFF_RST_VAL = '0;
  localparam logic RST_ACTIVE = 1'b0;
endpackage

// File: rtl/tff_bit.sv
// tff_bit: single T flip-flop with asynchronous active-low reset to a per-bit value
module tff_bit #(
  parameter logic RST_VAL = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic t,
  output logic q
);
  logic r_q;
  always_ff @(posedge clk or negedge rst)
    if (!rst) r_q <= RST_VAL;
    else      r_q <= r_q ^ t;
  assign q = r_q;
endmodule

// File: rtl/t_flip_flop.sv
// t_flip_flop: bank of WIDTH independent T flip-flops, each toggling when its t bit is set
module t_flip_flop
  import tff_pkg::*;
#(
  parameter int WIDTH = TFF_WIDTH,
  parameter logic [WIDTH-1:0] RST_VAL = TFF_RST_VAL[WIDTH-1:0]
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] t,
  output logic [WIDTH-1:0] t_out
);
  logic [WIDTH-1:0] w_q;
  if (WIDTH < 1 || WIDTH > TFF_MAX_WIDTH) begin : g_bad_width
    $error("t_flip_flop: WIDTH %0d outside 1..%0d", WIDTH, TFF_MAX_WIDTH);
  end
  for (genvar i = 0; i < WIDTH; i++) begin : g_bit
    tff_bit #(.RST_VAL(RST_VAL[i])) u_bit (
      .clk (clk),
      .rst (rst),
      .t   (t[i]),
      .q   (w_q[i])
    );
  end
  assign t_out = w_q;
  a_rst_hold: assert property (@(posedge clk) (rst == RST_ACTIVE) |-> (t_out == RST_VAL));
  a_toggle: assert property (@(posedge clk) disable iff (rst == RST_ACTIVE)
    (rst != RST_ACTIVE) |=> (t_out == $past(t_out ^ t)));
endmodule

// File: tb/tb_t_flip_flop.sv
// tb_t_flip_flop: vector table plus scoreboarded random run on 1-bit and 4-bit instances
module tb_t_flip_flop;
  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       t1 = 1'b0;
  logic [3:0] t4 = 4'b0000;
  logic       q1;
  logic [3:0] q4;
  logic       m1;
  logic [3:0] m4;
  logic       exp1_q[$];
  logic [3:0] exp4_q[$];
  int n_tests = 0;
  int n_fail = 0;

  typedef struct {
    logic       t1;
    logic [3:0] t4;
    logic       e1;
    logic [3:0] e4;
  } vec_t;
  vec_t vecs[5];

  always #10 clk = ~clk;

  t_flip_flop #(.WIDTH(1)) u_dut1 (
    .clk   (clk),
    .rst   (rst),
    .t     (t1),
    .t_out (q1)
  );

  t_flip_flop #(.WIDTH(4), .RST_VAL(4'b1010)) u_dut4 (
    .clk   (clk),
    .rst   (rst),
    .t     (t4),
    .t_out (q4)
  );

  task automatic check(input string nm, input logic e1, input logic [3:0] e4);
    n_tests += 2;
    if (q1 !== e1) begin
      n_fail++;
      $display("FAIL %s w1: got %b want %b", nm, q1, e1);
    end
    if (q4 !== e4) begin
      n_fail++;
      $display("FAIL %s w4: got %b want %b", nm, q4, e4);
    end
  endtask

  task automatic cycle(input logic tv1, input logic [3:0] tv4,
                       input logic e1, input logic [3:0] e4, input string nm);
    t1 = tv1;
    t4 = tv4;
    exp1_q.push_back(e1);
    exp4_q.push_back(e4);
    @(negedge clk);
    check(nm, exp1_q.pop_front(), exp4_q.pop_front());
  endtask

  // reset lands between edges, is held across one edge with t all ones, released on a falling edge
  task automatic async_reset(input int dly, input string nm);
    #(dly) rst = 1'b0;
    #1 check({nm, "_async"}, 1'b0, 4'b1010);
    t1 = 1'b1;
    t4 = 4'b1111;
    @(negedge clk);
    check({nm, "_hold"}, 1'b0, 4'b1010);
    rst = 1'b1;
    m1 = 1'b0;
    m4 = 4'b1010;
  endtask

  initial begin
    logic       tv1;
    logic [3:0] tv4;
    #2 rst = 1'b0;
    t1 = 1'b1;
    t4 = 4'b1111;
    #3 check("rst_async", 1'b0, 4'b1010);
    @(negedge clk);
    check("rst_hold", 1'b0, 4'b1010);
    rst = 1'b1;
    vecs = '{
      '{1'b0, 4'b0000, 1'b0, 4'b1010},
      '{1'b0, 4'b0000, 1'b0, 4'b1010},
      '{1'b1, 4'b0110, 1'b1, 4'b1100},
      '{1'b1, 4'b0110, 1'b0, 4'b1010},
      '{1'b1, 4'b0110, 1'b1, 4'b1100}
    };
    for (int i = 0; i < 5; i++)
      cycle(vecs[i].t1, vecs[i].t4, vecs[i].e1, vecs[i].e4, $sformatf("vec%0d", i));
    async_reset(5, "mid");
    cycle(1'b1, 4'b0110, 1'b1, 4'b1100, "resume1");
    cycle(1'b1, 4'b0110, 1'b0, 4'b1010, "resume2");
    m1 = 1'b0;
    m4 = 4'b1010;
    for (int i = 0; i < 200; i++) begin
      if ($urandom_range(0, 15) == 0) begin
        async_reset(int'($urandom_range(1, 8)), "rand_rst");
      end else begin
        tv1 = 1'($urandom);
        tv4 = 4'($urandom);
        cycle(tv1, tv4, m1 ^ tv1, m4 ^ tv4, "rand");
        m1 = m1 ^ tv1;
        m4 = m4 ^ tv4;
      end
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: bench did not finish, got timeout want completion");
    $fatal(1);
  end
endmodule
